// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, IMEM/DMEM wait handling.
// Define PIPE_HAZARD_PERF_EN to add the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_do_read_ctrl_ex,
    input  logic [4:0]  wr_reg_idx_ex,
    input  logic [4:0]  r1_reg_idx_id,
    input  logic [4:0]  r2_reg_idx_id,
    input  logic        r1_used_id,
    input  logic        r2_used_id,
    input  logic        redirect_ex,
    input  logic        imem_ready,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        id_ex_enable,
    output logic        ex_mem_enable,
    output logic        mem_wb_enable,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        ex_mem_clear,
    output logic        mem_wb_clear,
`ifdef PIPE_HAZARD_PERF_EN
    output logic        dmem_fault,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`else
    output logic        dmem_fault
`endif
);

    localparam int unsigned CntW = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DMEM_TIMEOUT);

    typedef enum logic [0:0] {StRun, StDmemWait} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            squash_q;

    logic timeout;
    logic dmem_stall;
    logic load_use;

    always_comb begin
        timeout    = (state_q == StDmemWait) && !dmem_ready && (cnt_q == CntMax);
        // A timed-out access is treated as completed, so it never stalls.
        dmem_stall = !dmem_ready && (dmem_req_mem || (state_q == StDmemWait)) && !timeout;
        load_use   = mem_do_read_ctrl_ex && (wr_reg_idx_ex != 5'd0) &&
                     ((r1_used_id && (r1_reg_idx_id == wr_reg_idx_ex)) ||
                      (r2_used_id && (r2_reg_idx_id == wr_reg_idx_ex)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (dmem_req_mem && !dmem_ready) begin
                        state_q <= StDmemWait;
                        cnt_q   <= CntW'(1);
                    end
                end
                StDmemWait: begin
                    if (dmem_ready || timeout) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
            endcase
            // The squash flag only moves when the front end is actually evaluated.
            if (!dmem_stall) begin
                if (redirect_ex) begin
                    squash_q <= !imem_ready;
                end else if (!load_use && imem_ready) begin
                    squash_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_clear   = 1'b0;
        id_ex_clear   = 1'b0;
        ex_mem_clear  = 1'b0;
        mem_wb_clear  = 1'b0;
        dmem_fault    = 1'b0;
        if (reset) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            if_id_clear   = 1'b1;
            id_ex_clear   = 1'b1;
            ex_mem_clear  = 1'b1;
            mem_wb_clear  = 1'b1;
        end else begin
            dmem_fault = timeout;
            if (dmem_stall) begin
                pc_enable     = 1'b0;
                if_id_enable  = 1'b0;
                id_ex_enable  = 1'b0;
                ex_mem_enable = 1'b0;
                mem_wb_clear  = 1'b1;
            end else if (redirect_ex) begin
                if_id_clear = 1'b1;
                id_ex_clear = 1'b1;
            end else if (load_use) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_ex_clear  = 1'b1;
            end else if (!imem_ready) begin
                pc_enable   = 1'b0;
                if_id_clear = 1'b1;
            end else if (squash_q) begin
                if_id_clear = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_enable && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_ex && !dmem_stall && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (DMEM_TIMEOUT 255 and 3) against a priority model.
module tb_pipeline_hazard_ctrl;

    // Packed view: {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr,
    //               ex_mem_clr, mem_wb_clr, dmem_fault}
    localparam logic [9:0] RST = 10'b00000_1111_0;
    localparam logic [9:0] DEF = 10'b11111_0000_0;
    localparam logic [9:0] LU  = 10'b00111_0100_0;
    localparam logic [9:0] RDR = 10'b11111_1100_0;
    localparam logic [9:0] FW  = 10'b01111_1000_0;
    localparam logic [9:0] SQ  = 10'b11111_1000_0;
    localparam logic [9:0] DST = 10'b00001_0001_0;
    localparam logic [9:0] TO  = 10'b11111_0000_1;

    logic clk = 1'b0;
    logic reset;
    logic mem_do_read_ctrl_ex;
    logic [4:0] wr_reg_idx_ex, r1_reg_idx_id, r2_reg_idx_id;
    logic r1_used_id, r2_used_id, redirect_ex, imem_ready, dmem_req_mem, dmem_ready;

    logic pc_e [2], ifid_e [2], idex_e [2], exmem_e [2], memwb_e [2];
    logic ifid_c [2], idex_c [2], exmem_c [2], memwb_c [2], fault [2];
    logic [9:0] obs [2];
    logic [31:0] sc [2], fc [2];

    int checks = 0;
    int errors = 0;

    int unsigned tmo [2] = '{255, 3};
    bit          m_wait [2];
    int unsigned m_cnt [2];
    bit          m_sq [2];
    int unsigned m_sc [2];
    int unsigned m_fc [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign obs[g] = {pc_e[g], ifid_e[g], idex_e[g], exmem_e[g], memwb_e[g],
                         ifid_c[g], idex_c[g], exmem_c[g], memwb_c[g], fault[g]};
`ifndef PIPE_HAZARD_PERF_EN
        assign sc[g] = '0;
        assign fc[g] = '0;
`endif
        pipeline_hazard_ctrl #(.DMEM_TIMEOUT(g == 0 ? 255 : 3)) dut (
            .clk                (clk),
            .reset              (reset),
            .mem_do_read_ctrl_ex(mem_do_read_ctrl_ex),
            .wr_reg_idx_ex      (wr_reg_idx_ex),
            .r1_reg_idx_id      (r1_reg_idx_id),
            .r2_reg_idx_id      (r2_reg_idx_id),
            .r1_used_id         (r1_used_id),
            .r2_used_id         (r2_used_id),
            .redirect_ex        (redirect_ex),
            .imem_ready         (imem_ready),
            .dmem_req_mem       (dmem_req_mem),
            .dmem_ready         (dmem_ready),
            .pc_enable          (pc_e[g]),
            .if_id_enable       (ifid_e[g]),
            .id_ex_enable       (idex_e[g]),
            .ex_mem_enable      (exmem_e[g]),
            .mem_wb_enable      (memwb_e[g]),
            .if_id_clear        (ifid_c[g]),
            .id_ex_clear        (idex_c[g]),
            .ex_mem_clear       (exmem_c[g]),
            .mem_wb_clear       (memwb_c[g]),
`ifdef PIPE_HAZARD_PERF_EN
            .dmem_fault         (fault[g]),
            .stall_cycles       (sc[g]),
            .flush_count        (fc[g])
`else
            .dmem_fault         (fault[g])
`endif
        );
    end

    function automatic bit m_timeout(input int k);
        return m_wait[k] && !dmem_ready && (m_cnt[k] == tmo[k]);
    endfunction

    function automatic bit m_dstall(input int k);
        return !m_timeout(k) && !dmem_ready && (dmem_req_mem || m_wait[k]);
    endfunction

    function automatic bit m_loaduse();
        if (!mem_do_read_ctrl_ex || wr_reg_idx_ex == 5'd0) return 1'b0;
        return (r1_used_id && r1_reg_idx_id == wr_reg_idx_ex) ||
               (r2_used_id && r2_reg_idx_id == wr_reg_idx_ex);
    endfunction

    function automatic logic [9:0] model_out(input int k);
        logic pc, ife, ide, xe, me, ic, dc, xc, mc;
        if (reset) return RST;
        {pc, ife, ide, xe, me} = 5'b11111;
        {ic, dc, xc, mc} = 4'b0000;
        if (m_dstall(k)) begin
            {pc, ife, ide, xe} = 4'b0000;
            mc = 1'b1;
        end else if (redirect_ex) begin
            ic = 1'b1;
            dc = 1'b1;
        end else if (m_loaduse()) begin
            pc  = 1'b0;
            ife = 1'b0;
            dc  = 1'b1;
        end else if (!imem_ready) begin
            pc = 1'b0;
            ic = 1'b1;
        end else if (m_sq[k]) begin
            ic = 1'b1;
        end
        return {pc, ife, ide, xe, me, ic, dc, xc, mc, m_timeout(k)};
    endfunction

    task automatic model_step(input int k);
        bit st;
        logic [9:0] o;
        if (reset) begin
            m_wait[k] = 0; m_cnt[k] = 0; m_sq[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            return;
        end
        st = m_dstall(k);
        o  = model_out(k);
        if (!o[9]) m_sc[k]++;
        if (redirect_ex && !st) m_fc[k]++;
        // m_cnt counts stalled cycles of the current access
        if (st) begin
            m_wait[k] = 1;
            m_cnt[k]++;
        end else begin
            m_wait[k] = 0;
            m_cnt[k] = 0;
        end
        if (!st) begin
            if (redirect_ex) m_sq[k] = !imem_ready;
            else if (!m_loaduse() && imem_ready) m_sq[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Called just after a posedge; checks at the negedge and returns just after the next posedge.
    task automatic step(input string tag, input bit c0, input logic [9:0] e0,
                        input bit c1, input logic [9:0] e1);
        @(negedge clk);
        if (c0) chk({tag, "/t255"}, 32'(obs[0]), 32'(e0));
        if (c1) chk({tag, "/t3"}, 32'(obs[1]), 32'(e1));
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model[%0d]", k), 32'(obs[k]), 32'(model_out(k)));
`ifdef PIPE_HAZARD_PERF_EN
            chk($sformatf("stall_cycles[%0d]", k), sc[k], m_sc[k]);
            chk($sformatf("flush_count[%0d]", k), fc[k], m_fc[k]);
`endif
            model_step(k);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_do_read_ctrl_ex = 0; wr_reg_idx_ex = 0; r1_reg_idx_id = 0; r2_reg_idx_id = 0;
        r1_used_id = 0; r2_used_id = 0; redirect_ex = 0; imem_ready = 1;
        dmem_req_mem = 0; dmem_ready = 1;
    endtask

    initial begin
        reset = 1;
        idle();
        step("reset", 1, RST, 1, RST);
        reset = 0;
        step("idle", 1, DEF, 1, DEF);

        mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 5; r1_reg_idx_id = 5; r1_used_id = 1;
        step("load_use", 1, LU, 1, LU);
        idle();
        step("after_lu", 1, DEF, 1, DEF);
        mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 0; r1_reg_idx_id = 0; r1_used_id = 1;
        step("lu_x0", 1, DEF, 1, DEF);
        idle();

        redirect_ex = 1;
        step("redirect", 1, RDR, 1, RDR);
        imem_ready = 0;
        step("redir_nordy", 1, RDR, 1, RDR);
        redirect_ex = 0;
        step("fetch_wait1", 1, FW, 1, FW);
        step("fetch_wait2", 1, FW, 1, FW);
        imem_ready = 1;
        step("squash", 1, SQ, 1, SQ);
        step("squash_done", 1, DEF, 1, DEF);

        dmem_req_mem = 1; dmem_ready = 0; redirect_ex = 1;
        step("dwait1", 1, DST, 1, DST);
        step("dwait2", 1, DST, 1, DST);
        step("dwait3", 1, DST, 1, DST);
        step("dwait4", 1, DST, 1, RDR | 10'd1);
        dmem_ready = 1;
        step("dwait_end", 1, RDR, 1, RDR);
        idle();
        step("dwait_idle", 1, DEF, 1, DEF);

        dmem_req_mem = 1; dmem_ready = 0;
        step("tmo1", 1, DST, 1, DST);
        step("tmo2", 1, DST, 1, DST);
        step("tmo3", 1, DST, 1, DST);
        step("tmo_fault", 1, DST, 1, TO);
        dmem_req_mem = 0;
        step("tmo_after", 1, DST, 1, DEF);
        dmem_ready = 1;
        step("tmo_drain", 1, DEF, 1, DEF);

        dmem_req_mem = 1; dmem_ready = 0;
        step("pre_rst1", 1, DST, 1, DST);
        step("pre_rst2", 1, DST, 1, DST);
        #2 reset = 1;
        #1;
        chk("rst_async/t255", 32'(obs[0]), 32'(RST));
        chk("rst_async/t3", 32'(obs[1]), 32'(RST));
        step("rst_mid", 1, RST, 1, RST);
        reset = 0;
        idle();
        step("rst_release", 1, DEF, 1, DEF);

        mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 7; r2_reg_idx_id = 7; r2_used_id = 1;
        step("perf_lu1", 1, LU, 1, LU);
        idle();
        step("perf_gap", 1, DEF, 1, DEF);
        mem_do_read_ctrl_ex = 1; wr_reg_idx_ex = 9; r1_reg_idx_id = 9; r1_used_id = 1;
        step("perf_lu2", 1, LU, 1, LU);
        idle();
        redirect_ex = 1;
        step("perf_rdr", 1, RDR, 1, RDR);
        idle();
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall", sc[0], 32'd2);
        chk("perf_flush", fc[0], 32'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            reset               = ($urandom_range(63) == 0);
            mem_do_read_ctrl_ex = ($urandom_range(9) < 4);
            wr_reg_idx_ex       = 5'($urandom_range(3));
            r1_reg_idx_id       = 5'($urandom_range(3));
            r2_reg_idx_id       = 5'($urandom_range(3));
            r1_used_id          = 1'($urandom);
            r2_used_id          = 1'($urandom);
            redirect_ex         = ($urandom_range(9) < 2);
            imem_ready          = ($urandom_range(9) < 7);
            dmem_req_mem        = ($urandom_range(3) == 0);
            dmem_ready          = ($urandom_range(9) < 5);
            step("rand", 0, DEF, 0, DEF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
